sd_block_sequencer: RTL and testbench

//  Sequences ZPU-initiated SD sector transfers between the ZPU register interface
//  (ZPU_OUT2/OUT3, ZPU_RD/WR strobes) and the hps_io block-device handshake.
//  - Latches the LBA and issues sd_rd/sd_wr, then tracks sd_ack.
//  - Owns port B of the 512-byte sector buffer: address counter, write strobe, reset of pointer.
//  - Reports io_done/busy/timeout status back to the ZPU status byte.

---
 rtl/sd_block_sequencer_if.sv | 40 ++++
 rtl/sd_block_sequencer.sv | 176 +++++++++++++++++
 tb/tb_sd_block_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_sequencer_if.sv
// ZPU register side and hps_io block-device side of the SD sector sequencer.
// The slave modport is the sequencer; the master modport is the ZPU/hps_io environment.
interface sd_block_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic              zpu_lba;
    logic              zpu_block_rd;
    logic              zpu_block_wr;
    logic              zpu_io_wr;
    logic              zpu_data_wr;
    logic              zpu_data_rd;
    logic [31:0]       zpu_wdata;

    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;

    logic [ADDR_W-1:0] buf_addr;
    logic              buf_wr;
    logic [7:0]        buf_wdata;

    logic              io_done;
    logic              busy;
    logic              timeout;

    modport master (
        output zpu_lba, zpu_block_rd, zpu_block_wr, zpu_io_wr,
               zpu_data_wr, zpu_data_rd, zpu_wdata, sd_ack,
        input  sd_lba, sd_rd, sd_wr, buf_addr, buf_wr, buf_wdata,
               io_done, busy, timeout
    );

    modport slave (
        input  zpu_lba, zpu_block_rd, zpu_block_wr, zpu_io_wr,
               zpu_data_wr, zpu_data_rd, zpu_wdata, sd_ack,
        output sd_lba, sd_rd, sd_wr, buf_addr, buf_wr, buf_wdata,
               io_done, busy, timeout
    );
endinterface

// File: rtl/sd_block_sequencer.sv
// Sequences ZPU-initiated SD sector transfers against the hps_io handshake and
// owns port B of the 512-byte sector buffer.
module sd_block_sequencer #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                clk_sys,
    input  logic                reset,
    sd_block_sequencer_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic              r_data_wr_d1;
    logic              r_data_wr_d2;
    logic              r_data_rd_q;
    logic              r_blk_rd_q;
    logic              r_blk_wr_q;

    logic              w_data_wr_evt;
    logic              w_data_rd_evt;
    logic              w_blk_rd_rise;
    logic              w_blk_wr_rise;

    logic [31:0]       r_sd_lba;
    logic              r_sd_rd;
    logic              r_sd_wr;
    logic              r_io_done;
    logic              r_busy;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_sd_rd_nx;
    logic              w_sd_wr_nx;
    logic              w_io_done_nx;
    logic              w_timeout_nx;
    logic [CNT_W-1:0]  w_cnt_nx;

    logic [ADDR_W-1:0] r_buf_addr;
    logic              r_buf_wr;
    logic [7:0]        r_buf_wdata;

    assign w_data_wr_evt = r_data_wr_d1 & ~r_data_wr_d2;
    assign w_data_rd_evt = r_data_rd_q & ~bus.zpu_data_rd;
    assign w_blk_rd_rise = bus.zpu_block_rd & ~r_blk_rd_q;
    assign w_blk_wr_rise = bus.zpu_block_wr & ~r_blk_wr_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_data_wr_d1 <= 1'b0;
            r_data_wr_d2 <= 1'b0;
            r_data_rd_q  <= 1'b0;
            r_blk_rd_q   <= 1'b0;
            r_blk_wr_q   <= 1'b0;
        end else begin
            r_data_wr_d1 <= bus.zpu_data_wr;
            r_data_wr_d2 <= r_data_wr_d1;
            r_data_rd_q  <= bus.zpu_data_rd;
            r_blk_rd_q   <= bus.zpu_block_rd;
            r_blk_wr_q   <= bus.zpu_block_wr;
        end
    end

    // ZPU data accesses only reach the buffer or LBA register while no transfer runs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sd_lba    <= '0;
            r_buf_addr  <= '0;
            r_buf_wr    <= 1'b0;
            r_buf_wdata <= '0;
        end else begin
            r_buf_wr <= 1'b0;
            if (w_data_wr_evt && !r_busy) begin
                if (bus.zpu_lba) begin
                    r_sd_lba <= bus.zpu_wdata;
                end else begin
                    r_buf_wr    <= 1'b1;
                    r_buf_wdata <= bus.zpu_wdata[7:0];
                end
            end
            if (bus.zpu_io_wr) begin
                r_buf_addr <= '0;
            end else if (r_buf_wr || (w_data_rd_evt && !r_busy)) begin
                r_buf_addr <= r_buf_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_io_done <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_sd_rd   <= w_sd_rd_nx;
            r_sd_wr   <= w_sd_wr_nx;
            r_io_done <= w_io_done_nx;
            r_busy    <= (w_state_nx != S_IDLE);
            r_timeout <= w_timeout_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    // A read edge beats a simultaneous write edge; request edges outside IDLE are dropped.
    always_comb begin
        w_state_nx   = r_state;
        w_sd_rd_nx   = r_sd_rd;
        w_sd_wr_nx   = r_sd_wr;
        w_io_done_nx = r_io_done;
        w_timeout_nx = r_timeout;
        w_cnt_nx     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_blk_rd_rise || w_blk_wr_rise) begin
                    w_sd_rd_nx   = w_blk_rd_rise;
                    w_sd_wr_nx   = ~w_blk_rd_rise;
                    w_io_done_nx = 1'b0;
                    w_timeout_nx = 1'b0;
                    w_cnt_nx     = '0;
                    w_state_nx   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.sd_ack) begin
                    w_sd_rd_nx = 1'b0;
                    w_sd_wr_nx = 1'b0;
                    w_state_nx = S_XFER;
                end else if (r_cnt == CNT_LAST) begin
                    w_sd_rd_nx   = 1'b0;
                    w_sd_wr_nx   = 1'b0;
                    w_timeout_nx = 1'b1;
                    w_io_done_nx = 1'b1;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_XFER: begin
                if (!bus.sd_ack) begin
                    w_io_done_nx = 1'b1;
                    w_state_nx   = S_IDLE;
                end
            end
            default: begin
                w_sd_rd_nx   = 1'b0;
                w_sd_wr_nx   = 1'b0;
                w_io_done_nx = 1'b1;
                w_state_nx   = S_IDLE;
            end
        endcase
    end

    assign bus.sd_lba    = r_sd_lba;
    assign bus.sd_rd     = r_sd_rd;
    assign bus.sd_wr     = r_sd_wr;
    assign bus.buf_addr  = r_buf_addr;
    assign bus.buf_wr    = r_buf_wr;
    assign bus.buf_wdata = r_buf_wdata;
    assign bus.io_done   = r_io_done;
    assign bus.busy      = r_busy;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer; inputs change and outputs are sampled 1ns after each rising edge.
module tb_sd_block_sequencer;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;

    logic clk_sys;
    logic reset;
    int   checks;
    int   errors;

    sd_block_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    sd_block_sequencer #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.zpu_block_rd = 1'b1;
        tick(3);
        checks++;
        if ({bus.io_done, bus.sd_rd, bus.sd_wr, bus.busy, bus.timeout} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_flags io_done,sd_rd,sd_wr,busy,timeout=%b exp=10000",
                     {bus.io_done, bus.sd_rd, bus.sd_wr, bus.busy, bus.timeout});
        end
        checks++;
        if (bus.buf_addr !== 9'd0 || bus.buf_wr !== 1'b0 || bus.sd_lba !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs buf_addr=%0d buf_wr=%b sd_lba=%h exp 0/0/0",
                     bus.buf_addr, bus.buf_wr, bus.sd_lba);
        end
        bus.zpu_block_rd = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
        checks++;
        if (bus.sd_rd !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release sd_rd=%b busy=%b exp 0/0", bus.sd_rd, bus.busy);
        end
    endtask

    task automatic test_lba_read();
        bus.zpu_lba     = 1'b1;
        bus.zpu_wdata   = 32'h0000_1234;
        bus.zpu_data_wr = 1'b1;
        tick(1);
        checks++;
        if (bus.sd_lba !== 32'h0) begin
            errors++;
            $display("[TB] FAIL lba_latency sd_lba=%h exp=00000000", bus.sd_lba);
        end
        bus.zpu_data_wr = 1'b0;
        tick(1);
        checks++;
        if (bus.sd_lba !== 32'h0000_1234 || bus.buf_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lba_write sd_lba=%h buf_wr=%b exp 00001234/0", bus.sd_lba, bus.buf_wr);
        end
        bus.zpu_lba      = 1'b0;
        bus.zpu_block_rd = 1'b1;
        tick(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.io_done, bus.busy} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL rd_request sd_rd,sd_wr,io_done,busy=%b exp=1001",
                     {bus.sd_rd, bus.sd_wr, bus.io_done, bus.busy});
        end
        bus.sd_ack = 1'b1;
        tick(1);
        checks++;
        if ({bus.sd_rd, bus.io_done, bus.busy} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rd_ack sd_rd,io_done,busy=%b exp=001", {bus.sd_rd, bus.io_done, bus.busy});
        end
        tick(9);
        checks++;
        if (bus.io_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_xfer io_done=%b exp=0", bus.io_done);
        end
        bus.sd_ack = 1'b0;
        tick(1);
        checks++;
        if ({bus.io_done, bus.busy, bus.sd_rd} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rd_done io_done,busy,sd_rd=%b exp=100", {bus.io_done, bus.busy, bus.sd_rd});
        end
        bus.zpu_block_rd = 1'b0;
        tick(1);
    endtask

    task automatic test_buffer_fill();
        logic [17:0] expv;
        logic [17:0] gotv;
        bus.zpu_data_rd = 1'b1;
        tick(1);
        bus.zpu_data_rd = 1'b0;
        tick(1);
        checks++;
        if (bus.buf_addr !== 9'd1) begin
            errors++;
            $display("[TB] FAIL read_advance buf_addr=%0d exp=1", bus.buf_addr);
        end
        bus.zpu_io_wr = 1'b1;
        tick(1);
        bus.zpu_io_wr = 1'b0;
        checks++;
        if (bus.buf_addr !== 9'd0) begin
            errors++;
            $display("[TB] FAIL io_rewind buf_addr=%0d exp=0", bus.buf_addr);
        end
        for (int i = 0; i < 513; i++) begin
            bus.zpu_wdata   = 32'hA5A5_0000 | (i & 255);
            bus.zpu_data_wr = 1'b1;
            tick(1);
            bus.zpu_data_wr = 1'b0;
            tick(1);
            expv = {1'b1, 9'(i), 8'(i)};
            gotv = {bus.buf_wr, bus.buf_addr, bus.buf_wdata};
            checks++;
            if (gotv !== expv) begin
                errors++;
                $display("[TB] FAIL fill_%0d buf_wr,addr,wdata=%b/%0d/%h exp=%b/%0d/%h",
                         i, gotv[17], gotv[16:8], gotv[7:0], expv[17], expv[16:8], expv[7:0]);
            end
        end
        tick(1);
        checks++;
        if (bus.buf_addr !== 9'd1 || bus.buf_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_end buf_addr=%0d buf_wr=%b exp 1/0", bus.buf_addr, bus.buf_wr);
        end
        bus.zpu_wdata   = 32'h0000_00AB;
        bus.zpu_data_wr = 1'b1;
        tick(1);
        bus.zpu_data_wr = 1'b0;
        tick(1);
        bus.zpu_io_wr = 1'b1;
        tick(1);
        bus.zpu_io_wr = 1'b0;
        checks++;
        if (bus.buf_addr !== 9'd0 || bus.buf_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rewind_priority buf_addr=%0d buf_wr=%b exp 0/0", bus.buf_addr, bus.buf_wr);
        end
    endtask

    task automatic test_back_to_back();
        bus.zpu_block_rd = 1'b1;
        bus.zpu_block_wr = 1'b1;
        tick(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL simul_req sd_rd,sd_wr=%b exp=10", {bus.sd_rd, bus.sd_wr});
        end
        bus.sd_ack = 1'b1;
        tick(1);
        bus.zpu_block_wr = 1'b0;
        tick(1);
        bus.zpu_block_wr = 1'b1;
        bus.zpu_wdata    = 32'h0000_0077;
        bus.zpu_data_wr  = 1'b1;
        tick(1);
        bus.zpu_data_wr  = 1'b0;
        tick(1);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.buf_wr, bus.busy} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL busy_ignore sd_rd,sd_wr,buf_wr,busy=%b exp=0001",
                     {bus.sd_rd, bus.sd_wr, bus.buf_wr, bus.busy});
        end
        bus.sd_ack = 1'b0;
        tick(1);
        checks++;
        if ({bus.io_done, bus.busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_done io_done,busy=%b exp=10", {bus.io_done, bus.busy});
        end
        tick(4);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.busy, bus.buf_addr} !== {3'b000, 9'd0}) begin
            errors++;
            $display("[TB] FAIL no_queue sd_rd,sd_wr,busy=%b buf_addr=%0d exp 000/0",
                     {bus.sd_rd, bus.sd_wr, bus.busy}, bus.buf_addr);
        end
        bus.zpu_block_rd = 1'b0;
        bus.zpu_block_wr = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout();
        bus.zpu_block_wr = 1'b1;
        tick(1);
        checks++;
        if ({bus.sd_wr, bus.sd_rd, bus.io_done} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL wr_request sd_wr,sd_rd,io_done=%b exp=100", {bus.sd_wr, bus.sd_rd, bus.io_done});
        end
        tick(TIMEOUT - 1);
        checks++;
        if ({bus.sd_wr, bus.timeout} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL pre_timeout sd_wr,timeout=%b exp=10", {bus.sd_wr, bus.timeout});
        end
        tick(1);
        checks++;
        if ({bus.sd_wr, bus.timeout, bus.io_done, bus.busy} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL timeout sd_wr,timeout,io_done,busy=%b exp=0110",
                     {bus.sd_wr, bus.timeout, bus.io_done, bus.busy});
        end
        bus.zpu_block_wr = 1'b0;
        bus.zpu_block_rd = 1'b1;
        tick(1);
        checks++;
        if ({bus.sd_rd, bus.timeout, bus.io_done} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL timeout_clear sd_rd,timeout,io_done=%b exp=100",
                     {bus.sd_rd, bus.timeout, bus.io_done});
        end
        bus.sd_ack = 1'b1;
        tick(2);
        bus.sd_ack = 1'b0;
        tick(1);
        bus.zpu_block_rd = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_in_xfer();
        bus.zpu_block_rd = 1'b1;
        tick(1);
        bus.sd_ack = 1'b1;
        tick(1);
        checks++;
        if (bus.busy !== 1'b1 || bus.io_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL xfer_entry busy=%b io_done=%b exp 1/0", bus.busy, bus.io_done);
        end
        reset            = 1'b1;
        bus.zpu_block_rd = 1'b0;
        tick(1);
        checks++;
        if ({bus.io_done, bus.busy, bus.sd_rd, bus.sd_lba} !== {3'b100, 32'h0}) begin
            errors++;
            $display("[TB] FAIL xfer_reset io_done,busy,sd_rd=%b sd_lba=%h exp 100/00000000",
                     {bus.io_done, bus.busy, bus.sd_rd}, bus.sd_lba);
        end
        reset = 1'b0;
        tick(2);
        bus.sd_ack = 1'b0;
        tick(2);
        checks++;
        if ({bus.io_done, bus.busy, bus.sd_rd, bus.sd_wr} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL late_ack io_done,busy,sd_rd,sd_wr=%b exp=1000",
                     {bus.io_done, bus.busy, bus.sd_rd, bus.sd_wr});
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.zpu_lba      = 1'b0;
        bus.zpu_block_rd = 1'b0;
        bus.zpu_block_wr = 1'b0;
        bus.zpu_io_wr    = 1'b0;
        bus.zpu_data_wr  = 1'b0;
        bus.zpu_data_rd  = 1'b0;
        bus.zpu_wdata    = 32'h0;
        bus.sd_ack       = 1'b0;
        test_reset();
        test_lba_read();
        test_buffer_fill();
        test_back_to_back();
        test_timeout();
        test_reset_in_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
